// File: rtl/display_source_ctrl_if.sv
// display_source_ctrl_if: bundle between the display source controller and its environment.
// Inputs to the controller: btn (raw step button), auto_en, freeze, src_valid[3:0], src0..3_data[31:0].
// Outputs from the controller: disp_data[31:0], cur_src[1:0], blank, switch_pulse.
interface display_source_ctrl_if;
    logic        btn;
    logic        auto_en;
    logic        freeze;
    logic [3:0]  src_valid;
    logic [31:0] src0_data;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
    logic [31:0] src3_data;
    logic [31:0] disp_data;
    logic [1:0]  cur_src;
    logic        blank;
    logic        switch_pulse;
    modport master (
        output btn, auto_en, freeze, src_valid, src0_data, src1_data, src2_data, src3_data,
        input  disp_data, cur_src, blank, switch_pulse
    );
    modport slave (
        input  btn, auto_en, freeze, src_valid, src0_data, src1_data, src2_data, src3_data,
        output disp_data, cur_src, blank, switch_pulse
    );
endinterface

// File: rtl/display_source_ctrl.sv
// display_source_ctrl: picks which of four 32-bit sources drives the 8-digit hex display.
// Ports: clk, rst_n (async, active low), bus (slave modport): debounced manual stepping or
// timed auto-rotation over valid sources, blanking to zero when none is valid.
module display_source_ctrl #(
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    display_source_ctrl_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state_q, state_d;
    logic            btn_s1_q, btn_s2_q;
    logic            db_q, db_d, db_prev_q, press_q;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [HW-1:0]   dwell_q, dwell_d;
    logic [1:0]      cur_q, cur_d, nxt, low;
    logic            sw_q, sw_d, blank_q;
    logic [31:0]     disp_q, disp_d, sel;
    logic            adv;

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (btn_s2_q != db_q) begin
            db_cnt_d = db_cnt_q + DW'(1);
            if (db_cnt_q == DB_LAST) begin
                db_d     = btn_s2_q;
                db_cnt_d = '0;
            end
        end
    end

    // Descending loops let the nearest candidate win.
    always_comb begin
        nxt = cur_q;
        for (int i = 3; i >= 1; i--)
            if (bus.src_valid[cur_q + 2'(i)]) nxt = cur_q + 2'(i);
        low = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (bus.src_valid[i]) low = 2'(i);
    end

    assign sel = (cur_q == 2'd0) ? bus.src0_data :
                 (cur_q == 2'd1) ? bus.src1_data :
                 (cur_q == 2'd2) ? bus.src2_data : bus.src3_data;

    always_comb begin
        adv     = !bus.src_valid[cur_q] || (bus.auto_en ? dwell_q == HOLD_LAST : press_q);
        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
        sw_d    = 1'b0;
        if (state_q == BLANK) begin
            if (|bus.src_valid) begin
                state_d = SHOW;
                cur_d   = low;
                dwell_d = '0;
                sw_d    = 1'b1;
            end
        end else if (~|bus.src_valid) begin
            state_d = BLANK;
        end else if (adv) begin
            cur_d   = nxt;
            dwell_d = '0;
            sw_d    = nxt != cur_q;
        end else if (bus.auto_en) begin
            dwell_d = dwell_q + HW'(1);
        end
        // The data register samples the pre-edge selection, so a new source lands one edge later.
        disp_d = bus.freeze ? disp_q : (state_q == SHOW ? sel : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            db_q      <= 1'b0;
            db_cnt_q  <= '0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            state_q   <= BLANK;
            cur_q     <= 2'd0;
            dwell_q   <= '0;
            sw_q      <= 1'b0;
            blank_q   <= 1'b1;
            disp_q    <= 32'd0;
        end else begin
            btn_s1_q  <= bus.btn;
            btn_s2_q  <= btn_s1_q;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            state_q   <= state_d;
            cur_q     <= cur_d;
            dwell_q   <= dwell_d;
            sw_q      <= sw_d;
            blank_q   <= state_d == BLANK;
            disp_q    <= disp_d;
        end
    end

    assign bus.disp_data    = disp_q;
    assign bus.cur_src      = cur_q;
    assign bus.blank        = blank_q;
    assign bus.switch_pulse = sw_q;
endmodule

// File: tb/tb_display_source_ctrl.sv
// tb_display_source_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_display_source_ctrl;
    localparam int H = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    display_source_ctrl_if bus();
    display_source_ctrl #(.HOLD_CYCLES(H), .DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state of what should be on screen.
    logic        m_blank = 1'b1;
    logic [1:0]  m_cur = 2'd0;
    int          m_dwell = 0;
    logic        m_sw = 1'b0;
    logic [31:0] m_disp = 32'd0;
    logic        m_lvl = 1'b0;
    logic [1:0]  m_rise = 2'b00;
    bit          hist[$];

    function automatic logic [1:0] next_valid(input logic [1:0] c, input logic [3:0] v);
        for (int k = 1; k < 4; k++)
            if (v[(int'(c) + k) % 4]) return 2'((int'(c) + k) % 4);
        return c;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[k]) return 2'(k);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_blank = 1'b1; m_cur = 2'd0; m_dwell = 0; m_sw = 1'b0; m_disp = 32'd0;
        m_lvl = 1'b0; m_rise = 2'b00;
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(1'b0);
    endtask

    task automatic model_step();
        logic [31:0] src [4];
        logic [3:0]  v;
        logic [31:0] nd;
        logic [1:0]  nv;
        logic        press;
        bit          flip;
        src   = '{bus.src0_data, bus.src1_data, bus.src2_data, bus.src3_data};
        v     = bus.src_valid;
        press = m_rise[1];
        // hist[k] is btn as sampled k edges ago; the synchronizer adds two edges of delay.
        hist.push_front(bus.btn);
        flip = 1'b1;
        for (int k = 2; k < D + 2; k++) if (hist[k] == m_lvl) flip = 1'b0;
        m_rise = {m_rise[0], flip & ~m_lvl};
        if (flip) m_lvl = ~m_lvl;
        void'(hist.pop_back());
        nd = bus.freeze ? m_disp : (m_blank ? 32'd0 : src[m_cur]);
        if (m_blank) begin
            m_sw = 1'b0;
            if (v != 0) begin
                m_blank = 1'b0; m_cur = lowest(v); m_dwell = 0; m_sw = 1'b1;
            end
        end else if (v == 0) begin
            m_blank = 1'b1; m_sw = 1'b0;
        end else if (!v[m_cur] || (bus.auto_en ? m_dwell == H - 1 : press)) begin
            nv = next_valid(m_cur, v);
            m_sw = nv != m_cur; m_cur = nv; m_dwell = 0;
        end else begin
            m_sw = 1'b0;
            if (bus.auto_en) m_dwell++;
        end
        m_disp = nd;
    endtask

    always begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (rst_n) begin
            chk("cur", 32'(bus.cur_src), 32'(m_cur));
            chk("blank", 32'(bus.blank), 32'(m_blank));
            chk("pulse", 32'(bus.switch_pulse), 32'(m_sw));
            chk("disp", bus.disp_data, m_disp);
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        bus.src_valid = v;
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.switch_pulse) cnt++;
        end
    endtask

    int cnt, last, idx, lat;
    logic [1:0] seq [5];

    initial begin
        bus.btn = 0; bus.auto_en = 0; bus.freeze = 0; bus.src_valid = 4'b0000;
        bus.src0_data = 32'h1111_0000; bus.src1_data = 32'h2222_0001;
        bus.src2_data = 32'h3333_0002; bus.src3_data = 32'h4444_0003;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("idle_blank", 32'(bus.blank), 32'd1);
            chk("idle_disp", bus.disp_data, 32'd0);
        end

        drive(4'b0100);
        tick(1);
        chk("exit_cur", 32'(bus.cur_src), 32'd2);
        chk("exit_blank", 32'(bus.blank), 32'd0);
        chk("exit_pulse", 32'(bus.switch_pulse), 32'd1);
        tick(1);
        chk("exit_disp", bus.disp_data, 32'h3333_0002);
        chk("exit_pulse_once", 32'(bus.switch_pulse), 32'd0);

        // Auto rotation over 1011.
        @(negedge clk);
        bus.src_valid = 4'b0000;
        bus.src0_data = 32'd0; bus.src1_data = 32'd1; bus.src2_data = 32'd2; bus.src3_data = 32'd3;
        tick(2);
        @(negedge clk);
        bus.auto_en = 1'b1;
        bus.src_valid = 4'b1011;
        tick(1);
        chk("auto_start", 32'(bus.cur_src), 32'd0);
        seq = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        last = 0; idx = 0;
        for (int k = 1; k <= 41; k++) begin
            tick(1);
            if (bus.switch_pulse) begin
                if (idx < 5) chk("auto_seq", 32'(bus.cur_src), 32'(seq[idx]));
                chk("auto_gap", 32'(k - last), 32'd8);
                last = k; idx++;
            end
        end
        chk("auto_count", 32'(idx), 32'd5);

        // Manual stepping with a bouncing button.
        @(negedge clk);
        bus.auto_en = 1'b0;
        bus.src_valid = 4'b0001;
        tick(1);
        drive(4'b1111);
        chk("man_start", 32'(bus.cur_src), 32'd0);
        bus.btn = 1'b1;
        @(negedge clk); bus.btn = 1'b0;
        @(negedge clk); bus.btn = 1'b1;
        count_pulses(10, cnt);
        @(negedge clk); bus.btn = 1'b0;
        count_pulses(12, last);
        chk("bounce_pulses", 32'(cnt + last), 32'd1);
        chk("bounce_cur", 32'(bus.cur_src), 32'd1);
        @(negedge clk); bus.btn = 1'b1;
        tick(3);
        @(negedge clk); bus.btn = 1'b0;
        count_pulses(14, cnt);
        chk("glitch_pulses", 32'(cnt), 32'd0);
        chk("glitch_cur", 32'(bus.cur_src), 32'd1);

        // Invalidated source and blanking.
        drive(4'b0011);
        tick(1);
        drive(4'b0001);
        tick(1);
        chk("inval_cur", 32'(bus.cur_src), 32'd0);
        chk("inval_pulse", 32'(bus.switch_pulse), 32'd1);
        drive(4'b0000);
        tick(1);
        chk("to_blank", 32'(bus.blank), 32'd1);
        tick(1);
        chk("blank_disp", bus.disp_data, 32'd0);

        // Freeze across a 3 -> 0 switch.
        @(negedge clk);
        bus.src0_data = 32'hC0DE_0000; bus.src3_data = 32'hC0DE_0003;
        bus.src_valid = 4'b1000;
        tick(2);
        chk("frz_pre", bus.disp_data, 32'hC0DE_0003);
        @(negedge clk);
        bus.freeze = 1'b1;
        bus.src_valid = 4'b0001;
        tick(1);
        chk("frz_cur", 32'(bus.cur_src), 32'd0);
        chk("frz_pulse", 32'(bus.switch_pulse), 32'd1);
        chk("frz_hold", bus.disp_data, 32'hC0DE_0003);
        tick(2);
        chk("frz_hold2", bus.disp_data, 32'hC0DE_0003);
        @(negedge clk);
        bus.freeze = 1'b0;
        tick(1);
        chk("frz_release", bus.disp_data, 32'hC0DE_0000);

        // Clean press latency: 2 + DEBOUNCE + 1 + 1 edges.
        drive(4'b1111);
        tick(2);
        @(negedge clk);
        bus.btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick(1);
            if (bus.switch_pulse) lat = k;
        end
        chk("press_latency", 32'(lat), 32'(2 + D + 1 + 1));
        @(negedge clk); bus.btn = 1'b0;
        tick(D + 4);

        // Random stimulus, checked every cycle by the model.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.src_valid = 4'($urandom);
            if ($urandom_range(0, 24) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 5) == 0) bus.freeze = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 6) == 0) bus.btn = ~bus.btn;
            bus.src0_data = $urandom; bus.src1_data = $urandom;
            if ($urandom_range(0, 3) == 0) bus.src2_data = $urandom;
            if ($urandom_range(0, 3) == 0) bus.src3_data = $urandom;
        end

        // Asynchronous reset mid-dwell.
        @(negedge clk);
        bus.auto_en = 1'b1; bus.freeze = 1'b0; bus.btn = 1'b0;
        bus.src_valid = 4'b1111; bus.src1_data = 32'hDEAD_BEEF;
        tick(4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_disp", bus.disp_data, 32'd0);
        chk("rst_cur", 32'(bus.cur_src), 32'd0);
        chk("rst_blank", 32'(bus.blank), 32'd1);
        chk("rst_pulse", 32'(bus.switch_pulse), 32'd0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_source_ctrl.md
# display_source_ctrl

Controller that shares the board's single 8-digit hex display between up to four 32-bit requesters, such as PC, ALU result, memory data and cycle count. It decides which source is shown and drives the 32-bit `data` input of the display scanner. It supports two source-selection modes: a debounced push-button steps through sources by hand, or a timed auto-rotate dwells on each source in turn. In both modes, sources that are not currently valid are skipped, and the display blanks to zero when no source is valid.

## Interface
- `HOLD_CYCLES`, default 50_000_000: dwell time per source in auto mode, in clk cycles; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new button level; must be ≥ 2.
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn`, in, 1: raw, asynchronous, bouncing step button. Active high.
- `auto_en`, in, 1: 1 selects auto-rotate, 0 selects manual stepping.
- `freeze`, in, 1: 1 holds `disp_data` at its current value. Selection logic keeps running.
- `src_valid`, in, 4: bit i = 1 means source i may be shown.
- `src0_data` … `src3_data`, in, 32 each: source data words.
- `disp_data`, out, 32: registered word for the display scanner.
- `cur_src`, out, 2: index of the selected source.
- `blank`, out, 1: 1 when no source is valid (BLANK state).
- `switch_pulse`, out, 1: one-cycle pulse on every change of `cur_src`.

## Operation
- Button conditioning:
  - `btn` passes through a 2-flop synchronizer.
  - The debounced level updates only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any return to the old value restarts the count.
  - A `press` strobe fires for one cycle on each 0→1 edge of the debounced level.
- "Next valid" search:
  - Scan indices `cur_src+1`, `+2`, `+3` modulo 4, in that order, and take the first with `src_valid` = 1.
  - If none is found and `src_valid[cur_src]` = 1, keep `cur_src`.
- FSM states: BLANK, SHOW.
  - BLANK:
    - `blank` = 1, `disp_data` = 0.
    - Exit when `src_valid` ≠ 0: go to SHOW, set `cur_src` to the lowest-index valid source, load the dwell counter with 0, pulse `switch_pulse`.
  - SHOW, transition priority:
    1. `src_valid` = 0: go to BLANK.
    2. `src_valid[cur_src]` = 0: advance to next valid immediately.
    3. `auto_en` = 0 and `press`: advance to next valid.
    4. `auto_en` = 1 and dwell counter = `HOLD_CYCLES-1`: advance to next valid.
  - Any advance clears the dwell counter.
  - `switch_pulse` fires only if `cur_src` actually changes.
  - `press` is ignored while `auto_en` = 1.
- Dwell counter:
  - Increments every cycle in SHOW while `auto_en` = 1.
  - Holds while `auto_en` = 0.
  - Width is ceil(log2(`HOLD_CYCLES`)).
  - Wraps to 0 on an advance, including when the advance keeps the same index.
- Data path:
  - Each cycle, `disp_data` ← the data of the source selected by `cur_src`, or 0 in BLANK.
  - While `freeze` = 1 the register holds, including across a BLANK transition.
  - When `freeze` is released, `disp_data` reloads on the next edge.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - `disp_data` = 0, `cur_src` = 0, `blank` = 1, `switch_pulse` = 0.
  - State = BLANK, counters = 0, debounced level = 0.
- Reset asserted mid-operation aborts immediately to these values. The first exit from BLANK occurs on the first edge after release on which `src_valid` ≠ 0.
- All outputs are registered.
- `cur_src` and `switch_pulse` change on the same edge as the decision.
- `disp_data` reflects the new source one edge after `cur_src` changes. For a given source, the latency from source data to `disp_data` is 1 cycle.
- Press latency: from a clean `btn` rising edge to the `cur_src` change is 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 (edge detect) + 1 (state update) cycles.
- Auto dwell: a source with unchanged `src_valid` is shown for exactly `HOLD_CYCLES` cycles.
- A `src_valid` change is seen one cycle later by the FSM, with no synchronizer; sources share `clk`.
- `freeze` acts on the same edge it is sampled.

## Test plan
- Use `HOLD_CYCLES` = 8 and `DEBOUNCE_CYCLES` = 4 for all scenarios.
- Reset with `src_valid` = 4'b0000, release → `blank` = 1 and `disp_data` = 0 indefinitely. Then set `src_valid` = 4'b0100 → `cur_src` = 2, `blank` = 0, one `switch_pulse`, and `disp_data` = `src2_data` one cycle later.
- `auto_en` = 1, `src_valid` = 4'b1011, srcN_data = 32'h0000_000N → `cur_src` sequence 0, 1, 3, 0, …, each held exactly 8 cycles, `switch_pulse` every 8 cycles.
- `auto_en` = 0, `src_valid` = 4'b1111, `btn` bounces 1-0-1 at 1-cycle spacing then holds high for 10 cycles → exactly one advance, 0→1. A 3-cycle glitch → no advance.
- In SHOW on `cur_src` = 1 with `src_valid` = 4'b0011, clear bit 1 → next cycle `cur_src` = 0. Then clear all bits → BLANK, `disp_data` = 0.
- `freeze` = 1 while the source changes 3→0 → `disp_data` holds its old value and `switch_pulse` still fires. Release `freeze` → `disp_data` = `src0_data` on the next edge.
- Assert `rst_n` = 0 mid-dwell, asynchronously between edges → outputs go to reset values without waiting for a clock edge.
